regfile_write_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 34 +++
 rtl/regfile_write_arbiter.sv | 99 +++++++++
 tb/tb_regfile_write_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register file types and sizes for the 32x32 three-ported register file
// and the logic that sits on its ports.
package regfile_pkg;

    localparam int unsigned RF_AW    = 5;
    localparam int unsigned RF_DW    = 32;
    localparam int unsigned RF_NREGS = 32;

    typedef logic [RF_AW-1:0] rf_addr_t;
    typedef logic [RF_DW-1:0] rf_data_t;

    typedef enum logic {
        WA_INIT,
        WA_RUN
    } wa_state_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request at or above
// ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int unsigned N  = 3,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    always_comb begin
        int unsigned idx;
        logic [IW-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= N) idx = idx - N;
            cand = IW'(idx);
            if (!any && req[cand]) begin
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
                any       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NREQ producers: zeroing sweep after
// reset, then one round-robin-arbitrated, registered write per cycle.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ      = 3,
    parameter int unsigned DW        = RF_DW,
    parameter int unsigned AW        = RF_AW,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*AW-1:0]       req_addr,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wa,
    output logic [DW-1:0]            rf_wd,
    output logic                     init_done,
    output logic [$clog2(NREQ)-1:0]  grant_id
);

    localparam int unsigned GW = $clog2(NREQ);
    // Extra counter bit keeps the terminal compare from aliasing on wrap.
    localparam logic [AW:0] LAST_ADDR = {1'b0, {AW{1'b1}}};

    wa_state_t       state_q, state_d;
    logic [AW:0]     init_cnt;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   gnt_idx;
    logic [NREQ-1:0] gnt;
    logic            any;
    logic            accept;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;

    rr_arbiter #(
        .N  (NREQ),
        .IW (GW)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        sel_addr  = req_addr[gnt_idx*AW +: AW];
        sel_data  = req_data[gnt_idx*DW +: DW];
        unique case (state_q)
            WA_INIT: begin
                if (init_cnt == LAST_ADDR) state_d = WA_RUN;
            end
            WA_RUN: begin
                req_ready = gnt;
                accept    = any;
            end
            default: state_d = WA_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INIT_ZERO ? WA_INIT : WA_RUN;
            init_cnt  <= '0;
            rr_ptr    <= '0;
            rf_we     <= 1'b0;
            rf_wa     <= '0;
            rf_wd     <= '0;
            grant_id  <= '0;
            init_done <= !INIT_ZERO;
        end else begin
            state_q <= state_d;
            if (state_q == WA_RUN) init_done <= 1'b1;
            if (state_q == WA_INIT) begin
                rf_we    <= 1'b1;
                rf_wa    <= init_cnt[AW-1:0];
                rf_wd    <= '0;
                grant_id <= '0;
                init_cnt <= init_cnt + 1'b1;
            end else if (accept) begin
                // r0 writes are consumed but never reach the register file.
                rf_we    <= (sel_addr != '0);
                rf_wa    <= sel_addr;
                rf_wd    <= sel_data;
                grant_id <= gnt_idx;
                rr_ptr   <= (gnt_idx == GW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a reference model feeding an
// expected-output queue and a behavioural register file on the write port.
module tb_regfile_write_arbiter;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    logic                 clk;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_wa;
    logic [DW-1:0]        rf_wd;
    logic                 init_done;
    logic [1:0]           grant_id;

    regfile_write_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .AW        (AW),
        .INIT_ZERO (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_done (init_done),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] rf_mem [32];
    always @(posedge clk) if (rf_we) rf_mem[rf_wa] <= rf_wd;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [1:0]    gid;
        logic          done;
    } exp_t;

    exp_t exp_q [$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic          m_run, m_done;
    int unsigned   m_cnt, m_ptr;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic [1:0]    m_gid;
    logic [NREQ-1:0] obs_ready;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int unsigned i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]        = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    // One clock: check req_ready against the model, queue the expected
    // registered outputs, then compare them after the edge.
    task automatic step();
        logic [NREQ-1:0] exp_ready;
        logic            found;
        int unsigned     g, idx;
        exp_t            e, got;
        #1;
        exp_ready = '0;
        found     = 1'b0;
        g         = 0;
        if (m_run) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            if (found) exp_ready[g] = 1'b1;
        end
        obs_ready = req_ready;
        check("req_ready", 32'(req_ready), 32'(exp_ready));

        if (reset) begin
            m_run = 1'b0; m_done = 1'b0; m_cnt = 0; m_ptr = 0;
            m_wa = '0; m_wd = '0; m_gid = '0;
            e = '{we: 1'b0, wa: '0, wd: '0, gid: '0, done: 1'b0};
        end else begin
            e.done = m_done | m_run;
            m_done = e.done;
            if (!m_run) begin
                e.we = 1'b1; m_wa = m_cnt[AW-1:0]; m_wd = '0; m_gid = '0;
                m_cnt++;
                if (m_cnt == 32) m_run = 1'b1;
            end else if (found) begin
                m_wa  = req_addr[g*AW +: AW];
                m_wd  = req_data[g*DW +: DW];
                m_gid = g[1:0];
                e.we  = (m_wa != '0);
                m_ptr = (g + 1) % NREQ;
            end else begin
                e.we = 1'b0;
            end
            e.wa = m_wa; e.wd = m_wd; e.gid = m_gid;
        end
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        check("rf_we",     32'(rf_we),     32'(got.we));
        check("rf_wa",     32'(rf_wa),     32'(got.wa));
        check("rf_wd",     rf_wd,          got.wd);
        check("grant_id",  32'(grant_id),  32'(got.gid));
        check("init_done", 32'(init_done), 32'(got.done));
    endtask

    initial begin
        int unsigned we_cnt;
        logic [1:0]    seq_g  [6];
        logic [AW-1:0] seq_wa [6];
        logic [1:0]    ord    [2];

        reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
        m_run = 1'b0; m_done = 1'b0; m_cnt = 0; m_ptr = 0;
        m_wa = '0; m_wd = '0; m_gid = '0; obs_ready = '0;

        // Reset values.
        step(); step();
        check("reset_we",   32'(rf_we),     32'd0);
        check("reset_done", 32'(init_done), 32'd0);

        // Partial sweep with all requesters knocking, then reset at init_cnt=12.
        reset = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'hC0 + i);
        for (int unsigned i = 0; i < 12; i++) step();
        check("mid_sweep_wa", 32'(rf_wa), 32'd11);
        reset = 1'b1;
        step();
        check("abort_we",   32'(rf_we),     32'd0);
        check("abort_done", 32'(init_done), 32'd0);
        reset = 1'b0;

        // Full sweep: 32 writes of zero, ready held low even with requests.
        we_cnt = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i == 10) req_valid = '0;
            step();
            if (rf_we === 1'b1) we_cnt++;
            if (i == 0) check("sweep_first_wa", 32'(rf_wa), 32'd0);
        end
        check("sweep_we_count", we_cnt, 32'd32);
        check("sweep_last_wa",  32'(rf_wa), 32'd31);
        check("done_before_33", 32'(init_done), 32'd0);
        step();
        check("done_at_33", 32'(init_done), 32'd1);
        check("we_at_33",   32'(rf_we),     32'd0);

        // Single requester 1 -> r5.
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        step();
        check("r1_ready", 32'(obs_ready), 32'b010);
        check("r1_wa",    32'(rf_wa),     32'd5);
        check("r1_wd",    rf_wd,          32'hDEADBEEF);
        check("r1_gid",   32'(grant_id),  32'd1);
        set_req(1, 1'b0, '0, '0);
        step();
        check("rf_r5", rf_mem[5], 32'hDEADBEEF);

        // Address 0 write is accepted but dropped.
        set_req(2, 1'b1, 5'd0, 32'hFFFFFFFF);
        step();
        check("a0_ready", 32'(obs_ready), 32'b100);
        check("a0_we",    32'(rf_we),     32'd0);
        set_req(2, 1'b0, '0, '0);
        step();
        check("rf_r0", rf_mem[0], 32'd0);

        // All three continuously valid from rr_ptr=0.
        for (int unsigned i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'hA0 + i);
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            seq_g[i]  = grant_id;
            seq_wa[i] = rf_wa;
        end
        for (int unsigned i = 0; i < 6; i++) begin
            check("rr_gid", 32'(seq_g[i]),  i % 3);
            check("rr_wa",  32'(seq_wa[i]), (i % 3) + 1);
        end
        req_valid = '0;

        // Move rr_ptr to 2, then same-address race between req 0 and req 2.
        set_req(1, 1'b1, 5'd4, 32'h44);
        step();
        set_req(1, 1'b0, '0, '0);
        set_req(0, 1'b1, 5'd7, 32'h11);
        set_req(2, 1'b1, 5'd7, 32'h22);
        step();
        ord[0] = grant_id;
        set_req(2, 1'b0, '0, '0);
        step();
        ord[1] = grant_id;
        set_req(0, 1'b0, '0, '0);
        step(); step();
        check("race_first",  32'(ord[0]), 32'd2);
        check("race_second", 32'(ord[1]), 32'd0);
        check("rf_r7",       rf_mem[7],   32'h11);

        // Reset in RUN with a request pending: not written until re-accepted.
        set_req(1, 1'b1, 5'd9, 32'h99);
        reset = 1'b1;
        step();
        check("run_rst_we",   32'(rf_we),     32'd0);
        check("run_rst_done", 32'(init_done), 32'd0);
        reset = 1'b0;
        for (int unsigned i = 0; i < 32; i++) step();
        check("rf_r9_swept", rf_mem[9], 32'd0);
        step();
        check("pend_wa", 32'(rf_wa), 32'd9);
        set_req(1, 1'b0, '0, '0);
        step();
        check("rf_r9", rf_mem[9], 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
